// File: rtl/pe_ctrl_pkg.sv
// Shared defaults and the modulo-increment helper for the PE array address sequencer.
package pe_ctrl_pkg;

  localparam int W_PE_GROUP_SIZE_DEF   = 4;
  localparam int O_PE_GROUP_SIZE_DEF   = 4;
  localparam int I_PE_GROUP_SIZE_DEF   = W_PE_GROUP_SIZE_DEF + O_PE_GROUP_SIZE_DEF - 1;
  localparam int W_PE_ADDR_WIDTH_DEF   = 2;
  localparam int O_PE_ADDR_WIDTH_DEF   = 2;
  localparam int I_PE_ADDR_WIDTH_DEF   = 3;
  localparam int I_BLOCK_COUNT_DEF     = 4;
  localparam int I_BLOCK_COUNT_WIDTH_DEF = 2;

  // Next value of a counter that runs 0..size-1 and then returns to 0.
  function automatic int wrap_inc(input int addr, input int size);
    return (addr == size - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/pe_controller_if.sv
// Scheduler <-> address sequencer bundle. Optional wrap flags exist only with PE_CTRL_WRAP_FLAGS_EN.
interface pe_controller_if #(
  parameter int W_PEAddrWidth     = 2,
  parameter int I_PEAddrWidth     = 3,
  parameter int O_PEAddrWidth     = 2,
  parameter int I_BlockCountWidth = 2
);
  // Enables are single-cycle strobes with no backpressure: an enable high at a
  // rising edge is always consumed at that edge; addresses are valid every cycle.
  logic                         EN_W;
  logic                         EN_I;
  logic                         EN_O_In;
  logic                         EN_O_Out;
  logic [W_PEAddrWidth-1:0]     W_PEAddr;
  logic [I_PEAddrWidth-1:0]     I_PEAddr;
  logic [O_PEAddrWidth-1:0]     O_In_PEAddr;
  logic [O_PEAddrWidth-1:0]     O_Out_PEAddr;
  logic [I_BlockCountWidth-1:0] I_BlockIdx;
`ifdef PE_CTRL_WRAP_FLAGS_EN
  logic                         W_Wrap;
  logic                         I_Wrap;
  logic                         O_In_Wrap;
  logic                         O_Out_Wrap;
  logic                         I_PassDone;

  modport master (
    output EN_W, EN_I, EN_O_In, EN_O_Out,
    input  W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr, I_BlockIdx,
    input  W_Wrap, I_Wrap, O_In_Wrap, O_Out_Wrap, I_PassDone
  );
  modport slave (
    input  EN_W, EN_I, EN_O_In, EN_O_Out,
    output W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr, I_BlockIdx,
    output W_Wrap, I_Wrap, O_In_Wrap, O_Out_Wrap, I_PassDone
  );
`else
  modport master (
    output EN_W, EN_I, EN_O_In, EN_O_Out,
    input  W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr, I_BlockIdx
  );
  modport slave (
    input  EN_W, EN_I, EN_O_In, EN_O_Out,
    output W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr, I_BlockIdx
  );
`endif
endinterface

// File: rtl/pe_mod_counter.sv
// Enable-driven modulo-SIZE counter; wrap marks the enabled cycle that returns it to 0.
module pe_mod_counter
  import pe_ctrl_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             en,
  output logic [WIDTH-1:0] addr,
  output logic             wrap
);

  if ((SIZE < 1) || ((SIZE - 1) >= (1 << WIDTH))) begin : g_bad_width
    $error("pe_mod_counter: WIDTH=%0d cannot hold SIZE-1=%0d", WIDTH, SIZE - 1);
  end

  // Combinational: tells the parent this edge takes the counter from SIZE-1 to 0.
  assign wrap = en && (addr == WIDTH'(SIZE - 1));

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      addr <= '0;
    end else if (en) begin
      addr <= WIDTH'(wrap_inc(int'(32'(addr)), SIZE));
    end
  end

endmodule

// File: rtl/pe_controller.sv
// Address sequencer for a 1-D PE array: four modulo counters plus an input-block index.
// Optional registered wrap/pass flags are built only when PE_CTRL_WRAP_FLAGS_EN is defined.
module pe_controller
  import pe_ctrl_pkg::*;
#(
  parameter int W_PEGroupSize     = W_PE_GROUP_SIZE_DEF,
  parameter int O_PEGroupSize     = O_PE_GROUP_SIZE_DEF,
  parameter int I_PEGroupSize     = W_PEGroupSize + O_PEGroupSize - 1,
  parameter int W_PEAddrWidth     = W_PE_ADDR_WIDTH_DEF,
  parameter int O_PEAddrWidth     = O_PE_ADDR_WIDTH_DEF,
  parameter int I_PEAddrWidth     = I_PE_ADDR_WIDTH_DEF,
  parameter int I_BlockCount      = I_BLOCK_COUNT_DEF,
  parameter int I_BlockCountWidth = I_BLOCK_COUNT_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           sclr_n,
  pe_controller_if.slave bus
);

  if ((I_BlockCount < 1) || ((I_BlockCount - 1) >= (1 << I_BlockCountWidth))) begin : g_bad_blk
    $error("pe_controller: I_BlockCountWidth=%0d cannot hold %0d", I_BlockCountWidth, I_BlockCount - 1);
  end

  logic w_wrap;
  logic i_wrap;
  logic o_in_wrap;
  logic o_out_wrap;
  logic [I_BlockCountWidth-1:0] blk_idx;
  logic blk_last;

  pe_mod_counter #(.SIZE(W_PEGroupSize), .WIDTH(W_PEAddrWidth)) u_w_cnt (
    .clk(clk), .sclr_n(sclr_n), .en(bus.EN_W), .addr(bus.W_PEAddr), .wrap(w_wrap)
  );

  pe_mod_counter #(.SIZE(I_PEGroupSize), .WIDTH(I_PEAddrWidth)) u_i_cnt (
    .clk(clk), .sclr_n(sclr_n), .en(bus.EN_I), .addr(bus.I_PEAddr), .wrap(i_wrap)
  );

  pe_mod_counter #(.SIZE(O_PEGroupSize), .WIDTH(O_PEAddrWidth)) u_o_in_cnt (
    .clk(clk), .sclr_n(sclr_n), .en(bus.EN_O_In), .addr(bus.O_In_PEAddr), .wrap(o_in_wrap)
  );

  pe_mod_counter #(.SIZE(O_PEGroupSize), .WIDTH(O_PEAddrWidth)) u_o_out_cnt (
    .clk(clk), .sclr_n(sclr_n), .en(bus.EN_O_Out), .addr(bus.O_Out_PEAddr), .wrap(o_out_wrap)
  );

  assign blk_last = (blk_idx == I_BlockCountWidth'(I_BlockCount - 1));

  // One input block is one complete I sweep, so the index steps on the I wrap.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      blk_idx <= '0;
    end else if (i_wrap) begin
      blk_idx <= blk_last ? '0 : blk_idx + 1'b1;
    end
  end

  assign bus.I_BlockIdx = blk_idx;

`ifdef PE_CTRL_WRAP_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      bus.W_Wrap     <= 1'b0;
      bus.I_Wrap     <= 1'b0;
      bus.O_In_Wrap  <= 1'b0;
      bus.O_Out_Wrap <= 1'b0;
      bus.I_PassDone <= 1'b0;
    end else begin
      bus.W_Wrap     <= w_wrap;
      bus.I_Wrap     <= i_wrap;
      bus.O_In_Wrap  <= o_in_wrap;
      bus.O_Out_Wrap <= o_out_wrap;
      bus.I_PassDone <= i_wrap && blk_last;
    end
  end
`else
  logic unused_wraps;
  assign unused_wraps = ^{w_wrap, o_in_wrap, o_out_wrap};
`endif

endmodule

// File: tb/tb_pe_controller.sv
// Randomized scoreboard bench for pe_controller against a modulo-arithmetic reference model.
module tb_pe_controller;

  localparam int W_SIZE = 4;
  localparam int O_SIZE = 4;
  localparam int I_SIZE = 7;
  localparam int BLKS   = 4;
`ifdef PE_CTRL_WRAP_FLAGS_EN
  localparam int EW = 16;
`else
  localparam int EW = 11;
`endif

  logic clk;
  logic sclr_n;

  pe_controller_if #(
    .W_PEAddrWidth(2), .I_PEAddrWidth(3), .O_PEAddrWidth(2), .I_BlockCountWidth(2)
  ) bus ();

  pe_controller dut (
    .clk(clk),
    .sclr_n(sclr_n),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int m_w, m_i, m_oi, m_oo, m_blk;
  bit f_w, f_i, f_oi, f_oo, f_pass;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  function automatic logic [EW-1:0] pack_model();
    logic [10:0] base;
    base = {2'(m_blk), 2'(m_oo), 2'(m_oi), 3'(m_i), 2'(m_w)};
`ifdef PE_CTRL_WRAP_FLAGS_EN
    return {f_pass, f_oo, f_oi, f_i, f_w, base};
`else
    return base;
`endif
  endfunction

  // driver: applies inputs after a falling edge and records the state expected after the next rising edge
  task automatic drive(input logic rst_n, input logic [3:0] en);
    @(negedge clk);
    sclr_n       = rst_n;
    bus.EN_W     = en[0];
    bus.EN_I     = en[1];
    bus.EN_O_In  = en[2];
    bus.EN_O_Out = en[3];
    if (!rst_n) begin
      m_w = 0; m_i = 0; m_oi = 0; m_oo = 0; m_blk = 0;
      f_w = 0; f_i = 0; f_oi = 0; f_oo = 0; f_pass = 0;
    end else begin
      f_w    = en[0] && (m_w == W_SIZE - 1);
      f_i    = en[1] && (m_i == I_SIZE - 1);
      f_oi   = en[2] && (m_oi == O_SIZE - 1);
      f_oo   = en[3] && (m_oo == O_SIZE - 1);
      f_pass = f_i && (m_blk == BLKS - 1);
      if (f_i) m_blk = (m_blk + 1) % BLKS;
      if (en[0]) m_w  = (m_w + 1) % W_SIZE;
      if (en[1]) m_i  = (m_i + 1) % I_SIZE;
      if (en[2]) m_oi = (m_oi + 1) % O_SIZE;
      if (en[3]) m_oo = (m_oo + 1) % O_SIZE;
    end
    exp_q.push_back(pack_model());
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
`ifdef PE_CTRL_WRAP_FLAGS_EN
      act = {bus.I_PassDone, bus.O_Out_Wrap, bus.O_In_Wrap, bus.I_Wrap, bus.W_Wrap,
             bus.I_BlockIdx, bus.O_Out_PEAddr, bus.O_In_PEAddr, bus.I_PEAddr, bus.W_PEAddr};
`else
      act = {bus.I_BlockIdx, bus.O_Out_PEAddr, bus.O_In_PEAddr, bus.I_PEAddr, bus.W_PEAddr};
`endif
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL state t=%0t got=%h want=%h (flags|blk,oo,oi,i,w)", $time, act, exp);
      end
    end
  end

  initial begin
    int waited;
    total = 0; bad = 0;
    sclr_n = 1'b0;
    bus.EN_W = 1'b0; bus.EN_I = 1'b0; bus.EN_O_In = 1'b0; bus.EN_O_Out = 1'b0;

    // reset dominates every enable
    repeat (2) drive(1'b0, 4'b1111);
    // W, I, O_In run together, O_Out held
    repeat (8) drive(1'b1, 4'b0111);
    // realign and run three-plus full I passes for the block index
    drive(1'b0, 4'b0000);
    repeat (28) drive(1'b1, 4'b0010);
    // O_Out on alternate cycles
    for (int k = 0; k < 8; k++) drive(1'b1, (k % 2 == 0) ? 4'b1000 : 4'b0000);
    // reset in the middle of a sweep at I=4, block 2, then resume
    drive(1'b0, 4'b0000);
    repeat (18) drive(1'b1, 4'b0010);
    drive(1'b0, 4'b0010);
    repeat (3) drive(1'b1, 4'b0010);
    // W alone to exercise its wrap
    repeat (10) drive(1'b1, 4'b0001);
    // random enables with occasional reset
    for (int k = 0; k < 400; k++)
      drive(($urandom_range(0, 24) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
    drive(1'b1, 4'b0000);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
